// File: rtl/memctrl_rr_arbiter.sv
`timescale 1ns/1ps
// Purpose: round-robin sharing of the memctrl SRAM port among NREQ requesters, with optional burst lock.
// Latency: MEM_* command one cycle after accept; RSP_VALID/RSP_RDATA registered RD_LAT edges after accept.
// Backpressure: REQ_READY is high only for the granted requester; others hold REQ_VALID until accepted.
module memctrl_rr_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic [NREQ-1:0]        REQ_VALID,
    output logic [NREQ-1:0]        REQ_READY,
    input  logic [NREQ-1:0]        REQ_WE,
    input  logic [NREQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NREQ*DATA_W-1:0] REQ_WDATA,
    output logic [NREQ-1:0]        RSP_VALID,
    output logic [DATA_W-1:0]      RSP_RDATA,
    output logic [ADDR_W-1:0]      MEM_ADDR,
    output logic                   MEM_CE,
    output logic                   MEM_CSB,
    output logic                   MEM_WEB,
    output logic                   MEM_OEB,
    output logic [DATA_W-1:0]      MEM_IDATA,
    input  logic [DATA_W-1:0]      MEM_ODATA
);

    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = $clog2(MAX_BURST + 1);

    typedef enum logic {ST_IDLE, ST_LOCK} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDW-1:0]      r_rr_ptr, w_rr_ptr_nxt;
    logic [IDW-1:0]      r_owner, w_owner_nxt;
    logic [CNTW-1:0]     r_burst_cnt, w_burst_cnt_nxt;

    logic                w_release;
    logic                w_grant_vld;
    logic [IDW-1:0]      w_grant_id;
    logic [NREQ-1:0]     w_ready;
    logic [IDW-1:0]      w_scan_idx [NREQ];

    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_we;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_ce, r_mem_csb, r_mem_web, r_mem_oeb;
    logic [DATA_W-1:0]   r_mem_idata;

    logic [RD_LAT-1:0]   r_tag_rd;
    logic [IDW-1:0]      r_tag_id [RD_LAT];
    logic [NREQ-1:0]     r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;

    // Scan order for re-arbitration: rr_ptr, rr_ptr+1, ... wrapped modulo NREQ.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            if (int'(r_rr_ptr) + k >= NREQ)
                w_scan_idx[k] = IDW'(int'(r_rr_ptr) + k - NREQ);
            else
                w_scan_idx[k] = IDW'(int'(r_rr_ptr) + k);
        end
    end

    // Next-state and grant: hold the lock while the owner streams, otherwise round-robin pick.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_owner_nxt     = r_owner;
        w_burst_cnt_nxt = r_burst_cnt;
        w_grant_vld     = 1'b0;
        w_grant_id      = r_owner;
        w_ready         = '0;
        w_release       = 1'b1;

        // The lock releases in the same cycle the owner drops valid or exhausts its burst.
        if (r_state == ST_LOCK)
            w_release = !REQ_VALID[r_owner] || (r_burst_cnt == CNTW'(MAX_BURST));

        if (!w_release) begin
            w_grant_vld      = 1'b1;
            w_grant_id       = r_owner;
            w_ready[r_owner] = 1'b1;
            w_burst_cnt_nxt  = r_burst_cnt + 1'b1;
        end else begin
            // Reverse scan so the lowest scan position (highest priority) wins.
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (REQ_VALID[w_scan_idx[k]]) begin
                    w_grant_vld = 1'b1;
                    w_grant_id  = w_scan_idx[k];
                end
            end
            if (w_grant_vld) begin
                w_ready[w_grant_id] = 1'b1;
                w_owner_nxt         = w_grant_id;
                w_burst_cnt_nxt     = CNTW'(1);
                w_rr_ptr_nxt        = (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;
                w_state_nxt         = (MAX_BURST > 1) ? ST_LOCK : ST_IDLE;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    assign REQ_READY = w_ready;

    // Select the granted requester's command fields.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == w_grant_id) begin
                w_sel_addr  = REQ_ADDR[i*ADDR_W +: ADDR_W];
                w_sel_wdata = REQ_WDATA[i*DATA_W +: DATA_W];
                w_sel_we    = REQ_WE[i];
            end
        end
    end

    // Arbiter state register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    // Registered memctrl command: active for one cycle per accepted beat; address/data hold otherwise.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_mem_addr  <= '0;
            r_mem_ce    <= 1'b0;
            r_mem_csb   <= 1'b1;
            r_mem_web   <= 1'b1;
            r_mem_oeb   <= 1'b1;
            r_mem_idata <= '0;
        end else if (w_grant_vld) begin
            r_mem_addr <= w_sel_addr;
            r_mem_ce   <= 1'b1;
            r_mem_csb  <= 1'b0;
            r_mem_web  <= ~w_sel_we;
            r_mem_oeb  <= w_sel_we;
            if (w_sel_we)
                r_mem_idata <= w_sel_wdata;
        end else begin
            r_mem_ce  <= 1'b0;
            r_mem_csb <= 1'b1;
            r_mem_web <= 1'b1;
            r_mem_oeb <= 1'b1;
        end
    end

    // Read tag pipe: one stage per cycle so the tag lines up with valid ODATA.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_tag_rd <= '0;
            for (int i = 0; i < RD_LAT; i++)
                r_tag_id[i] <= '0;
        end else begin
            r_tag_rd[0] <= w_grant_vld & ~w_sel_we;
            r_tag_id[0] <= w_grant_id;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_rd[i] <= r_tag_rd[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    // Read return: capture ODATA and pulse the issuing requester's valid.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (r_tag_rd[RD_LAT-1]) begin
                r_rsp_valid[r_tag_id[RD_LAT-1]] <= 1'b1;
                r_rsp_rdata                     <= MEM_ODATA;
            end
        end
    end

    assign MEM_ADDR  = r_mem_addr;
    assign MEM_CE    = r_mem_ce;
    assign MEM_CSB   = r_mem_csb;
    assign MEM_WEB   = r_mem_web;
    assign MEM_OEB   = r_mem_oeb;
    assign MEM_IDATA = r_mem_idata;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_RDATA = r_rsp_rdata;

endmodule

// File: tb/tb_memctrl_rr_arbiter.sv
`timescale 1ns/1ps
// Bench for memctrl_rr_arbiter: per-requester command queues, a memctrl behavioural model,
// and a scoreboard of expected grants, commands and read responses.
// A second instance with MAX_BURST=1 exercises pure per-beat round-robin.
module tb_memctrl_rr_arbiter;

    localparam int NREQ = 4, ADDR_W = 16, DATA_W = 8, RD_LAT = 3;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [1:0]        id;
        logic [DATA_W-1:0] data;
        logic [31:0]       due;
    } rsp_t;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    logic [NREQ-1:0]        req_valid = '0, req_ready, req_we = '0, rsp_valid;
    logic [NREQ*ADDR_W-1:0] req_addr = '0;
    logic [NREQ*DATA_W-1:0] req_wdata = '0;
    logic [DATA_W-1:0]      rsp_rdata, mem_idata, mem_odata;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_ce, mem_csb, mem_web, mem_oeb;

    logic [NREQ-1:0]        b_valid = '0, b_ready, b_rsp_valid;
    logic [NREQ*ADDR_W-1:0] b_addr = {16'd3, 16'd2, 16'd1, 16'd0};
    logic [DATA_W-1:0]      b_rsp_rdata, b_mem_idata;
    logic [ADDR_W-1:0]      b_mem_addr;
    logic                   b_mem_ce, b_mem_csb, b_mem_web, b_mem_oeb;

    memctrl_rr_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(4)) u_dut (
        .CLK(CLK), .RSTN(RSTN),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata),
        .MEM_ADDR(mem_addr), .MEM_CE(mem_ce), .MEM_CSB(mem_csb), .MEM_WEB(mem_web),
        .MEM_OEB(mem_oeb), .MEM_IDATA(mem_idata), .MEM_ODATA(mem_odata)
    );

    memctrl_rr_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(1)) u_dut_rr (
        .CLK(CLK), .RSTN(RSTN),
        .REQ_VALID(b_valid), .REQ_READY(b_ready), .REQ_WE(4'hF),
        .REQ_ADDR(b_addr), .REQ_WDATA({NREQ*DATA_W{1'b0}}),
        .RSP_VALID(b_rsp_valid), .RSP_RDATA(b_rsp_rdata),
        .MEM_ADDR(b_mem_addr), .MEM_CE(b_mem_ce), .MEM_CSB(b_mem_csb), .MEM_WEB(b_mem_web),
        .MEM_OEB(b_mem_oeb), .MEM_IDATA(b_mem_idata), .MEM_ODATA({DATA_W{1'b0}})
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory contents: SRAM model and the scoreboard's reference copy start identical.
    logic [DATA_W-1:0] mem     [0:65535];
    logic [DATA_W-1:0] ref_mem [0:65535];
    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a]     = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
            ref_mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
        end
    end

    // memctrl model: samples the command one edge after accept, ODATA valid RD_LAT edges after accept, X otherwise.
    logic [DATA_W-1:0] rd_s1;
    logic              rd_s1_v = 1'b0;
    initial mem_odata = 'x;
    always @(posedge CLK) begin
        if (mem_ce && !mem_csb && !mem_web)
            mem[mem_addr] = mem_idata;
        mem_odata <= rd_s1_v ? rd_s1 : 'x;
        rd_s1_v   <= mem_ce && !mem_csb && !mem_oeb;
        rd_s1     <= mem[mem_addr];
    end

    cmd_t        req_q [NREQ][$];
    int          grant_q [$];
    rsp_t        rsp_q [$];
    logic [NREQ-1:0] acc = '0;

    // Requester drivers: present the queue head, hold it until the accept edge, then advance.
    always @(posedge CLK) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i] && req_q[i].size() > 0)
                void'(req_q[i].pop_front());
            if (req_q[i].size() > 0) begin
                req_valid[i]                   = 1'b1;
                req_we[i]                      = req_q[i][0].we;
                req_addr[i*ADDR_W +: ADDR_W]   = req_q[i][0].addr;
                req_wdata[i*DATA_W +: DATA_W]  = req_q[i][0].wdata;
            end else begin
                req_valid[i]                   = 1'b0;
                req_we[i]                      = 1'b0;
                req_addr[i*ADDR_W +: ADDR_W]   = '0;
                req_wdata[i*DATA_W +: DATA_W]  = '0;
            end
        end
    end

    // Monitor: checks the command issued for the previous accept, read responses, and the next accept.
    int                cyc = 0;
    logic              pend = 1'b0, pend_we = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_idata = '0;
    always @(negedge CLK) begin
        int   id;
        rsp_t e;
        cyc++;
        if (!RSTN) begin
            acc       = '0;
            pend      = 1'b0;
            exp_addr  = '0;
            exp_idata = '0;
            rsp_q.delete();
        end else begin
            if (pend)
                check_val("mem_ctl_active", {mem_ce, mem_csb, mem_web, mem_oeb}, {1'b1, 1'b0, ~pend_we, pend_we});
            else
                check_val("mem_ctl_idle", {mem_ce, mem_csb, mem_web, mem_oeb}, 4'b0111);
            check_val("mem_addr", mem_addr, exp_addr);
            check_val("mem_idata", mem_idata, exp_idata);

            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    check_val("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = rsp_q.pop_front();
                    check_val("rsp_id", rsp_valid, 32'(1) << e.id);
                    check_val("rsp_data", rsp_rdata, e.data);
                    check_val("rsp_latency", cyc, e.due);
                end
            end else if (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
                check_val("rsp_missing", rsp_valid, 32'(1) << rsp_q[0].id);
                void'(rsp_q.pop_front());
            end

            acc  = req_valid & req_ready;
            pend = 1'b0;
            if (acc != '0) begin
                check_val("ready_onehot", $countones(req_ready), 1);
                id = 0;
                for (int i = NREQ - 1; i >= 0; i--)
                    if (acc[i]) id = i;
                if (grant_q.size() == 0)
                    check_val("grant_unexpected", acc, 0);
                else
                    check_val("grant_order", id, grant_q.pop_front());
                pend     = 1'b1;
                pend_we  = req_we[id];
                exp_addr = req_addr[id*ADDR_W +: ADDR_W];
                if (pend_we) begin
                    exp_idata          = req_wdata[id*DATA_W +: DATA_W];
                    ref_mem[exp_addr]  = exp_idata;
                end else begin
                    e.id   = 2'(id);
                    e.data = ref_mem[exp_addr];
                    e.due  = 32'(cyc + RD_LAT + 1);
                    rsp_q.push_back(e);
                end
            end
        end
    end

    // Per-beat round-robin instance: grants must rotate 0,1,2,3,... with a command every cycle.
    logic t4_on = 1'b0;
    int   t4_k  = 0;
    always @(negedge CLK) begin
        if (t4_on) begin
            check_val("rr_grant", b_ready, 32'(1) << (t4_k % NREQ));
            if (t4_k > 0) begin
                check_val("rr_mem_ce", b_mem_ce, 1);
                check_val("rr_mem_addr", b_mem_addr, (t4_k - 1) % NREQ);
            end
            t4_k++;
        end
    end

    function automatic int outstanding();
        int n = grant_q.size() + rsp_q.size();
        for (int i = 0; i < NREQ; i++) n += req_q[i].size();
        return n;
    endfunction

    task automatic wait_done(input string tag);
        int n = 0;
        while (outstanding() != 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check_val({tag, "_drained"}, outstanding(), 0);
        repeat (3) @(negedge CLK);
    endtask

    task automatic push_cmd(input int r, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d;
        req_q[r].push_back(c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // 1. Reset values, then idle with X on ODATA.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_val("rst_mem_ctl", {mem_ce, mem_csb, mem_web, mem_oeb}, 4'b0111);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_mem_idata", mem_idata, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_rdata", rsp_rdata, 0);
        @(posedge CLK); #1 RSTN = 1'b1;
        @(negedge CLK);
        check_val("post_rst_ready", req_ready, 0);
        check_val("post_rst_csb", mem_csb, 1);
        repeat (6) @(negedge CLK);
        check_val("xinj_rsp_valid", rsp_valid, 0);
        check_val("xinj_rdata_hold", rsp_rdata, 0);

        // 4. Pure round-robin with all four requesters valid continuously.
        @(posedge CLK); #1;
        b_valid = 4'hF;
        t4_on   = 1'b1;
        repeat (9) @(posedge CLK);
        #1;
        b_valid = 4'h0;
        t4_on   = 1'b0;

        // 2. Single read from requester 1.
        @(posedge CLK); #2;
        push_cmd(1, 1'b0, 16'h4C05, 8'h00);
        grant_q.push_back(1);
        wait_done("t2");

        // 3. Write then read-back of the same address, back-to-back.
        @(posedge CLK); #2;
        push_cmd(0, 1'b1, 16'h0003, 8'hA5);
        push_cmd(0, 1'b0, 16'h0003, 8'h00);
        grant_q.push_back(0);
        grant_q.push_back(0);
        wait_done("t3");

        // 5. Burst lock: requester 2 streams 6 beats while requester 3 wants one beat.
        @(posedge CLK); #2;
        for (int k = 0; k < 6; k++)
            push_cmd(2, k[0], 16'h2000 + 16'(k), 8'h10 + 8'(k));
        push_cmd(3, 1'b0, 16'h3000, 8'h00);
        foreach (grant_q[i]) ;
        grant_q.push_back(2); grant_q.push_back(2); grant_q.push_back(2); grant_q.push_back(2);
        grant_q.push_back(3); grant_q.push_back(2); grant_q.push_back(2);
        wait_done("t5");

        // 6. Reset with two reads in flight, then a clean read afterwards.
        @(posedge CLK); #2;
        push_cmd(1, 1'b0, 16'h0100, 8'h00);
        push_cmd(1, 1'b0, 16'h0200, 8'h00);
        grant_q.push_back(1);
        grant_q.push_back(1);
        begin
            int n = 0;
            while (grant_q.size() != 0 && n < 50) begin
                @(negedge CLK);
                n++;
            end
            check_val("t6_grants_taken", grant_q.size(), 0);
        end
        @(posedge CLK); #1 RSTN = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RSTN = 1'b1;
        repeat (8) @(negedge CLK);
        check_val("t6_no_stale_rsp", rsp_valid, 0);
        check_val("t6_ready_idle", req_ready, 0);
        @(posedge CLK); #2;
        push_cmd(1, 1'b0, 16'h0100, 8'h00);
        grant_q.push_back(1);
        wait_done("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
